swap_pass_sequencer: RTL

//  Controller for the 64-bit adjacent-bit-swap datapath. Accepts one word per job over a valid/ready handshake.

---
 rtl/swap_pass_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/swap_pass_sequencer.sv
// swap_pass_sequencer
//   Controller and datapath for an odd-even transposition network over one
//   WIDTH-bit word. A job (word + pass count P) is accepted over a
//   valid/ready handshake. The block then applies P passes, one per clk,
//   alternating EVEN and ODD swaps and always starting with EVEN. The
//   permuted word is then presented on an output valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   job offered on in_data / in_passes
//   in_ready   block can accept a job (IDLE only, low while rst)
//   in_data    word to permute
//   in_passes  number of passes P for this job (0 returns in_data unchanged)
//   out_valid  out_data holds a finished result
//   out_ready  consumer takes the result
//   out_data   permuted word (tracks the data register)
//   busy       high in RUN or DONE
module swap_pass_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_passes,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] even_d;
    logic [WIDTH-1:0] odd_d;
    logic [CNT_W-1:0] cnt_q;
    logic             phase_q;   // 0 = EVEN pass next, 1 = ODD pass next
    logic             accept;

    // Both pass results are computed purely from the current register, so
    // every swap in a pass sees pre-pass values.
    genvar k;
    generate
        for (k = 0; k < WIDTH/2; k++) begin : g_even
            assign even_d[2*k]   = data_q[2*k+1];
            assign even_d[2*k+1] = data_q[2*k];
        end
        for (k = 0; k < WIDTH/2-1; k++) begin : g_odd
            assign odd_d[2*k+1] = data_q[2*k+2];
            assign odd_d[2*k+2] = data_q[2*k+1];
        end
    endgenerate

    // End bits have no partner in an ODD pass.
    assign odd_d[0]       = data_q[0];
    assign odd_d[WIDTH-1] = data_q[WIDTH-1];

    assign accept = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = (in_passes != '0) ? RUN : DONE;
            RUN:  if (cnt_q == CNT_W'(1)) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers: load on accept, one pass per clk while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                data_q  <= in_data;
                cnt_q   <= in_passes;
                phase_q <= 1'b0;
            end else if (state == RUN) begin
                data_q  <= phase_q ? odd_d : even_d;
                cnt_q   <= cnt_q - CNT_W'(1);
                phase_q <= ~phase_q;
            end
        end
    end

    // Output logic. in_ready is gated by rst so nothing is taken during reset.
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        out_data  = data_q;
    end

endmodule
